pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Sequences the Y86 program counter against a multi-cycle instruction memory.
//  Issues fetch requests at pc and advances pc by the fetched instruction length.
//  Applies redirects from execute/writeback, holds on pipeline stall, and terminates on halt or fault.
//  Sits between the fetch stage and the imem port; sole owner of the architectural fetch PC.
// PARAMETERS
//  PC_W       48        width of pc / addresses
//  RESET_VEC  48'h0     pc value loaded on reset
//  MAX_WAIT   15        max cycles in FETCH without ack before ADR fault (>=1)
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset: synchronous, active-high
//  imem_req       out  1     fetch request; held high until ack/err/abort
//  imem_addr      out  PC_W  fetch address (= pc while imem_req)
//  imem_ack       in   1     fetch data valid this cycle
//  imem_err       in   1     memory address error (qualifies ack cycle or stands alone)
//  instr_len      in   4     length of fetched instr, valid with imem_ack; legal 1..10
//  instr_is_halt  in   1     fetched instr is HALT, valid with imem_ack
//  stall          in   1     downstream cannot accept next instruction
//  redirect_valid in   1     branch/ret correction
//  redirect_pc    in   PC_W  corrected target
//  pc             out  PC_W  current fetch PC
//  fetch_valid    out  1     instruction at pc accepted this cycle (combinational)
//  stat           out  3     1=AOK 2=HLT 3=ADR 4=INS
// BEHAVIOUR
//  - Reset: pc=RESET_VEC, state=IDLE, stat=AOK, wait_cnt=0, imem_req=0, fetch_valid=0.
//    rst mid-fetch drops imem_req on the following edge; any in-flight ack is ignored.
//  - States:
//    IDLE  -> FETCH next cycle (one dead cycle after reset/redirect).
//    FETCH (imem_req=1):
//      - err -> FAULT, stat=ADR.
//      - ack with instr_len 0 or >10 -> FAULT, stat=INS.
//      - ack with instr_is_halt -> HALT, stat=HLT, fetch_valid=1, pc unchanged.
//      - ack otherwise -> fetch_valid=1, pc<=pc+instr_len; ->HOLD if stall else ->FETCH.
//      - no ack: wait_cnt++ ; wait_cnt==MAX_WAIT-1 without ack -> FAULT, stat=ADR.
//    HOLD  (imem_req=0): stay while stall; ->FETCH when stall=0.
//    HALT, FAULT: imem_req=0, pc frozen, stat frozen; exit only via rst.
//  - Back-to-back: ack at cycle n with stall=0 -> new request at pc+len at cycle n+1.
//    Zero bubble.
//  - wait_cnt clears on every entry to FETCH.
//  - Redirect: in IDLE/FETCH/HOLD, redirect_valid wins over ack/err/timeout/stall.
//    pc<=redirect_pc, ->IDLE, fetch_valid forced 0, in-flight fetch abandoned.
//    Ignored in HALT/FAULT.
//  - Arithmetic: pc+instr_len zero-extended, modulo 2^PC_W (wrap, no fault).
//  - imem_addr = pc always; imem_req = (state==FETCH).
//  - err and ack same cycle: err wins (ADR).
// STRUCTURE
//  - Shared defines: STAT_AOK/HLT/ADR/INS codes, PC_W, MAX_INSTR_LEN=10, state encodings.
//  - Sub-module fetch_wait_timer: wait counter with clear/enable and expired flag.
//  - Everything else in one always block plus next-state logic.
// TESTING
//  - Reset, imem acks every fetch with len=2 at 1-cycle latency, no stall:
//    pc = 0,2,4,6 on consecutive acks; fetch_valid high each ack cycle.
//  - Ack at pc=0x10 with len=10, stall=1 for 3 cycles:
//    pc=0x1A, imem_req low 3 cycles, request at 0x1A on 4th cycle.
//  - Ack and redirect_valid (redirect_pc=0x100) same cycle:
//    fetch_valid=0, one IDLE cycle, then imem_req with imem_addr=0x100.
//  - No ack for 15 cycles with MAX_WAIT=15: stat=3, imem_req=0.
//    Later ack/redirect ignored until rst.
//  - Ack with len=0 -> stat=4.
//    Ack with instr_is_halt -> stat=2, pc held; both recover to pc=0, stat=1 after rst.
//  - pc=48'hFFFF_FFFF_FFFE, len=3 -> pc=1, stat stays AOK.
//    rst asserted during FETCH -> next cycle imem_req=0, pc=RESET_VEC.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// pc_fetch_ctrl_pkg : status codes, length limit and FSM states for the fetch PC sequencer
// Rev 1.0
//------------------------------------------------------------------------------
package pc_fetch_ctrl_pkg;

   localparam int DEFAULT_PC_W  = 48;
   localparam int MAX_INSTR_LEN = 10;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_HOLD  = 3'd2,
      ST_HALT  = 3'd3,
      ST_FAULT = 3'd4
   } fetch_state_e;

   function automatic logic len_legal(input logic [3:0] len);
      return (len != 4'd0) && (len <= 4'(MAX_INSTR_LEN));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_wait_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// pc_fetch_ctrl_wait_timer : counts unacknowledged FETCH cycles, flags the last allowed one
// Rev 1.0
//------------------------------------------------------------------------------
module pc_fetch_ctrl_wait_timer #(
   parameter int MAX_WAIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Expired marks the cycle in which a missing ack must become a fault.
   assign expired_o = (cnt_q == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// pc_fetch_ctrl : owns the Y86 fetch PC, sequences imem requests, redirects, halt and faults
// Rev 1.0
//------------------------------------------------------------------------------
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter int              PC_W      = DEFAULT_PC_W,
   parameter logic [PC_W-1:0] RESET_VEC = '0,
   parameter int              MAX_WAIT  = 15
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic            imem_err_i,
   input  logic [3:0]      instr_len_i,
   input  logic            instr_is_halt_i,
   input  logic            stall_i,
   input  logic            redirect_valid_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   output logic [PC_W-1:0] pc_o,
   output logic            fetch_valid_o,
   output logic [2:0]      stat_o
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [2:0]      stat_q, stat_d;
   logic            req_q;
   logic            wait_en;
   logic            wait_clr;
   logic            wait_expired;

   // Any cycle that is not a plain ack-less FETCH wait restarts the timeout window.
   assign wait_clr = ~wait_en;

   pc_fetch_ctrl_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (wait_clr),
      .en_i      (wait_en),
      .expired_o (wait_expired)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      stat_d        = stat_q;
      fetch_valid_o = 1'b0;
      wait_en       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (redirect_valid_i) begin
               pc_d = redirect_pc_i;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (redirect_valid_i) begin
               pc_d    = redirect_pc_i;
               state_d = ST_IDLE;
            end else if (imem_err_i) begin
               state_d = ST_FAULT;
               stat_d  = STAT_ADR;
            end else if (imem_ack_i) begin
               if (!len_legal(instr_len_i)) begin
                  state_d = ST_FAULT;
                  stat_d  = STAT_INS;
               end else if (instr_is_halt_i) begin
                  fetch_valid_o = 1'b1;
                  state_d       = ST_HALT;
                  stat_d        = STAT_HLT;
               end else begin
                  fetch_valid_o = 1'b1;
                  pc_d          = pc_q + PC_W'(instr_len_i);
                  state_d       = stall_i ? ST_HOLD : ST_FETCH;
               end
            end else if (wait_expired) begin
               state_d = ST_FAULT;
               stat_d  = STAT_ADR;
            end else begin
               wait_en = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid_i) begin
               pc_d    = redirect_pc_i;
               state_d = ST_IDLE;
            end else if (!stall_i) begin
               state_d = ST_FETCH;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_VEC;
         stat_q  <= STAT_AOK;
         req_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         stat_q  <= stat_d;
         req_q   <= (state_d == ST_FETCH);
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign stat_o      = stat_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_pc_fetch_ctrl : directed scenarios plus randomized traffic against a behavioural model
// Rev 1.0
//------------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

   localparam int              PC_W      = 48;
   localparam logic [PC_W-1:0] RESET_VEC = '0;
   localparam int              MAX_WAIT  = 15;
   localparam logic [63:0]     PC_MASK   = (64'd1 << PC_W) - 64'd1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req_o;
   logic [PC_W-1:0] imem_addr_o;
   logic            imem_ack_i = 1'b0;
   logic            imem_err_i = 1'b0;
   logic [3:0]      instr_len_i = 4'd0;
   logic            instr_is_halt_i = 1'b0;
   logic            stall_i = 1'b0;
   logic            redirect_valid_i = 1'b0;
   logic [PC_W-1:0] redirect_pc_i = '0;
   logic [PC_W-1:0] pc_o;
   logic            fetch_valid_o;
   logic [2:0]      stat_o;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: mode 0 idle, 1 requesting, 2 held by stall, 3 halted, 4 faulted
   logic [63:0] m_pc;
   int          m_mode;
   int          m_stat;
   int          m_wait;

   pc_fetch_ctrl #(
      .PC_W      (PC_W),
      .RESET_VEC (RESET_VEC),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .imem_req_o       (imem_req_o),
      .imem_addr_o      (imem_addr_o),
      .imem_ack_i       (imem_ack_i),
      .imem_err_i       (imem_err_i),
      .instr_len_i      (instr_len_i),
      .instr_is_halt_i  (instr_is_halt_i),
      .stall_i          (stall_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .pc_o             (pc_o),
      .fetch_valid_o    (fetch_valid_o),
      .stat_o           (stat_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      imem_ack_i       = 1'b0;
      imem_err_i       = 1'b0;
      instr_len_i      = 4'd0;
      instr_is_halt_i  = 1'b0;
      stall_i          = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic goto_fetch();
      do_reset();
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      #1;
      checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req_o); end
      checks++; if (pc_o !== RESET_VEC) begin failures++; $display("FAIL reset_pc got=%0h exp=%0h", pc_o, RESET_VEC); end
      checks++; if (stat_o !== 3'd1) begin failures++; $display("FAIL reset_stat got=%0d exp=1", stat_o); end
      checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL reset_fv got=%0h exp=0", fetch_valid_o); end
      rst = 1'b0;
      tick();
      #1;
      checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%0h exp=1", imem_req_o); end
   endtask

   task automatic test_sequential();
      goto_fetch();
      for (int i = 0; i < 4; i++) begin
         imem_ack_i  = 1'b1;
         instr_len_i = 4'd2;
         #1;
         checks++; if (imem_req_o !== 1'b1) begin failures++; $display("FAIL seq_req[%0d] got=%0h exp=1", i, imem_req_o); end
         checks++; if (imem_addr_o !== PC_W'(2 * i)) begin failures++; $display("FAIL seq_addr[%0d] got=%0h exp=%0h", i, imem_addr_o, 2 * i); end
         checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL seq_fv[%0d] got=%0h exp=1", i, fetch_valid_o); end
         tick();
      end
      imem_ack_i = 1'b0;
      #1;
      checks++; if (pc_o !== PC_W'(8)) begin failures++; $display("FAIL seq_final_pc got=%0h exp=8", pc_o); end
   endtask

   task automatic test_stall();
      goto_fetch();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = PC_W'(16'h0010);
      tick();
      redirect_valid_i = 1'b0;
      tick();
      imem_ack_i  = 1'b1;
      instr_len_i = 4'd10;
      stall_i     = 1'b1;
      #1;
      checks++; if (imem_addr_o !== PC_W'(16'h0010) || imem_req_o !== 1'b1) begin failures++; $display("FAIL stall_req_addr got=%0h req=%0h exp=10", imem_addr_o, imem_req_o); end
      checks++; if (fetch_valid_o !== 1'b1) begin failures++; $display("FAIL stall_fv got=%0h exp=1", fetch_valid_o); end
      tick();
      imem_ack_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         stall_i = (k < 2);
         #1;
         checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_hold_req[%0d] got=%0h exp=0", k, imem_req_o); end
         checks++; if (pc_o !== PC_W'(16'h001A)) begin failures++; $display("FAIL stall_pc[%0d] got=%0h exp=1a", k, pc_o); end
         tick();
      end
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== PC_W'(16'h001A)) begin failures++; $display("FAIL stall_resume got req=%0h addr=%0h exp req=1 addr=1a", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_redirect();
      imem_ack_i       = 1'b1;
      instr_len_i      = 4'd2;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = PC_W'(16'h0100);
      #1;
      checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL redir_fv got=%0h exp=0", fetch_valid_o); end
      tick();
      idle_inputs();
      #1;
      checks++; if (imem_req_o !== 1'b0 || pc_o !== PC_W'(16'h0100)) begin failures++; $display("FAIL redir_idle got req=%0h pc=%0h exp req=0 pc=100", imem_req_o, pc_o); end
      tick();
      #1;
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== PC_W'(16'h0100)) begin failures++; $display("FAIL redir_fetch got req=%0h addr=%0h exp req=1 addr=100", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_timeout();
      for (int k = 0; k < MAX_WAIT; k++) begin
         #1;
         checks++; if (imem_req_o !== 1'b1 || stat_o !== 3'd1) begin failures++; $display("FAIL tmo_wait[%0d] got req=%0h stat=%0d exp req=1 stat=1", k, imem_req_o, stat_o); end
         tick();
      end
      #1;
      checks++; if (stat_o !== 3'd3 || imem_req_o !== 1'b0) begin failures++; $display("FAIL tmo_fault got stat=%0d req=%0h exp stat=3 req=0", stat_o, imem_req_o); end
      for (int k = 0; k < 4; k++) begin
         imem_ack_i       = 1'b1;
         instr_len_i      = 4'd2;
         redirect_valid_i = 1'b1;
         redirect_pc_i    = PC_W'(16'h0200);
         #1;
         checks++; if (stat_o !== 3'd3 || imem_req_o !== 1'b0 || fetch_valid_o !== 1'b0 || pc_o !== PC_W'(16'h0100)) begin failures++; $display("FAIL tmo_frozen[%0d] got stat=%0d req=%0h fv=%0h pc=%0h", k, stat_o, imem_req_o, fetch_valid_o, pc_o); end
         tick();
      end
      do_reset();
      #1;
      checks++; if (stat_o !== 3'd1 || pc_o !== RESET_VEC) begin failures++; $display("FAIL tmo_recover got stat=%0d pc=%0h exp stat=1 pc=0", stat_o, pc_o); end
   endtask

   task automatic test_bad_len_and_halt();
      goto_fetch();
      imem_ack_i  = 1'b1;
      instr_len_i = 4'd0;
      #1;
      checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL ins_fv got=%0h exp=0", fetch_valid_o); end
      tick();
      idle_inputs();
      #1;
      checks++; if (stat_o !== 3'd4 || imem_req_o !== 1'b0) begin failures++; $display("FAIL ins_stat got stat=%0d req=%0h exp stat=4 req=0", stat_o, imem_req_o); end
      do_reset();
      #1;
      checks++; if (stat_o !== 3'd1 || pc_o !== RESET_VEC) begin failures++; $display("FAIL ins_recover got stat=%0d pc=%0h", stat_o, pc_o); end
      tick();
      imem_ack_i  = 1'b1;
      instr_len_i = 4'd2;
      tick();
      instr_len_i     = 4'd1;
      instr_is_halt_i = 1'b1;
      #1;
      checks++; if (fetch_valid_o !== 1'b1 || imem_addr_o !== PC_W'(2)) begin failures++; $display("FAIL halt_fv got fv=%0h addr=%0h exp fv=1 addr=2", fetch_valid_o, imem_addr_o); end
      tick();
      idle_inputs();
      tick();
      tick();
      #1;
      checks++; if (stat_o !== 3'd2 || pc_o !== PC_W'(2) || imem_req_o !== 1'b0) begin failures++; $display("FAIL halt_state got stat=%0d pc=%0h req=%0h exp 2/2/0", stat_o, pc_o, imem_req_o); end
      do_reset();
      #1;
      checks++; if (stat_o !== 3'd1 || pc_o !== RESET_VEC) begin failures++; $display("FAIL halt_recover got stat=%0d pc=%0h", stat_o, pc_o); end
   endtask

   task automatic test_err_with_ack();
      goto_fetch();
      imem_ack_i  = 1'b1;
      imem_err_i  = 1'b1;
      instr_len_i = 4'd2;
      #1;
      checks++; if (fetch_valid_o !== 1'b0) begin failures++; $display("FAIL err_fv got=%0h exp=0", fetch_valid_o); end
      tick();
      idle_inputs();
      #1;
      checks++; if (stat_o !== 3'd3 || pc_o !== RESET_VEC || imem_req_o !== 1'b0) begin failures++; $display("FAIL err_stat got stat=%0d pc=%0h req=%0h exp 3/0/0", stat_o, pc_o, imem_req_o); end
   endtask

   task automatic test_wrap_and_mid_reset();
      goto_fetch();
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 48'hFFFF_FFFF_FFFE;
      tick();
      redirect_valid_i = 1'b0;
      tick();
      imem_ack_i  = 1'b1;
      instr_len_i = 4'd3;
      #1;
      checks++; if (fetch_valid_o !== 1'b1 || imem_addr_o !== 48'hFFFF_FFFF_FFFE) begin failures++; $display("FAIL wrap_ack got fv=%0h addr=%0h", fetch_valid_o, imem_addr_o); end
      tick();
      imem_ack_i = 1'b0;
      #1;
      checks++; if (pc_o !== PC_W'(1) || stat_o !== 3'd1 || imem_req_o !== 1'b1) begin failures++; $display("FAIL wrap_pc got pc=%0h stat=%0d req=%0h exp 1/1/1", pc_o, stat_o, imem_req_o); end
      rst = 1'b1;
      tick();
      #1;
      checks++; if (imem_req_o !== 1'b0 || pc_o !== RESET_VEC) begin failures++; $display("FAIL midrst got req=%0h pc=%0h exp req=0 pc=0", imem_req_o, pc_o); end
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_pc   = 64'(RESET_VEC);
      m_mode = 0;
      m_stat = 1;
      m_wait = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (m_mode <= 2 && redirect_valid_i) begin
         m_pc   = 64'(redirect_pc_i);
         m_mode = 0;
      end else begin
         case (m_mode)
            0: begin m_mode = 1; m_wait = 0; end
            1: begin
               if (imem_err_i) begin
                  m_mode = 4; m_stat = 3;
               end else if (imem_ack_i) begin
                  if (instr_len_i < 4'd1 || instr_len_i > 4'd10) begin
                     m_mode = 4; m_stat = 4;
                  end else if (instr_is_halt_i) begin
                     m_mode = 3; m_stat = 2;
                  end else begin
                     m_pc   = (m_pc + 64'(instr_len_i)) & PC_MASK;
                     m_mode = stall_i ? 2 : 1;
                     m_wait = 0;
                  end
               end else begin
                  m_wait++;
                  if (m_wait >= MAX_WAIT) begin m_mode = 4; m_stat = 3; end
               end
            end
            2: if (!stall_i) begin m_mode = 1; m_wait = 0; end
            default: ;
         endcase
      end
   endtask

   task automatic test_random();
      logic exp_req;
      logic exp_fv;
      int   ack_pct;
      do_reset();
      model_reset();
      for (int it = 0; it < 3000; it++) begin
         ack_pct          = (it < 1500) ? 60 : 12;
         rst              = ($urandom_range(0, 99) < 2) || (m_mode >= 3 && $urandom_range(0, 9) == 0);
         stall_i          = ($urandom_range(0, 9) < 3);
         imem_ack_i       = !rst && ($urandom_range(0, 99) < ack_pct);
         imem_err_i       = !rst && ($urandom_range(0, 99) < 2);
         instr_is_halt_i  = ($urandom_range(0, 99) < 3);
         instr_len_i      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(11, 15) % 16) : 4'($urandom_range(1, 10));
         redirect_valid_i = ($urandom_range(0, 99) < 5);
         redirect_pc_i    = ($urandom_range(0, 3) == 0) ? (48'hFFFF_FFFF_FFF0 | PC_W'($urandom_range(0, 15)))
                                                        : PC_W'({$urandom(), $urandom()});
         #1;
         exp_req = (m_mode == 1);
         exp_fv  = (m_mode == 1) && imem_ack_i && !imem_err_i && !redirect_valid_i &&
                   (instr_len_i >= 4'd1) && (instr_len_i <= 4'd10);
         checks++; if (imem_req_o !== exp_req) begin failures++; $display("FAIL rnd_req it=%0d got=%0h exp=%0h", it, imem_req_o, exp_req); end
         checks++; if (pc_o !== m_pc[PC_W-1:0] || imem_addr_o !== m_pc[PC_W-1:0]) begin failures++; $display("FAIL rnd_pc it=%0d got pc=%0h addr=%0h exp=%0h", it, pc_o, imem_addr_o, m_pc[PC_W-1:0]); end
         checks++; if (stat_o !== 3'(m_stat)) begin failures++; $display("FAIL rnd_stat it=%0d got=%0d exp=%0d", it, stat_o, m_stat); end
         checks++; if (fetch_valid_o !== exp_fv) begin failures++; $display("FAIL rnd_fv it=%0d got=%0h exp=%0h", it, fetch_valid_o, exp_fv); end
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_sequential();
      test_stall();
      test_redirect();
      test_timeout();
      test_bad_len_and_halt();
      test_err_with_ack();
      test_wrap_and_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
